// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue stage: opcode/funct values, ALU operation
// codes, FSM states and the decoder's output record.
package alu_issue_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int OPRN_W  = 6;
  localparam int RADDR_W = 5;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_MULI  = 6'h1D;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h2C;

  localparam logic [OPRN_W-1:0] OPRN_NONE = 6'd0;
  localparam logic [OPRN_W-1:0] OPRN_ADD  = 6'd1;
  localparam logic [OPRN_W-1:0] OPRN_SUB  = 6'd2;
  localparam logic [OPRN_W-1:0] OPRN_MUL  = 6'd3;
  localparam logic [OPRN_W-1:0] OPRN_SRL  = 6'd4;
  localparam logic [OPRN_W-1:0] OPRN_SLL  = 6'd5;
  localparam logic [OPRN_W-1:0] OPRN_AND  = 6'd6;
  localparam logic [OPRN_W-1:0] OPRN_OR   = 6'd7;
  localparam logic [OPRN_W-1:0] OPRN_NOR  = 6'd8;
  localparam logic [OPRN_W-1:0] OPRN_SLT  = 6'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP2_REG     = 3'd0,
    OP2_SEXT    = 3'd1,
    OP2_ZEXT    = 3'd2,
    OP2_SHAMT   = 3'd3,
    OP2_CONST16 = 3'd4
  } op2_sel_t;

  typedef enum logic {
    OP1_REG = 1'b0,
    OP1_IMM = 1'b1
  } op1_sel_t;

  typedef struct packed {
    logic [OPRN_W-1:0]  oprn;
    op2_sel_t           op2_sel;
    op1_sel_t           op1_sel;
    logic [RADDR_W-1:0] dest;
    logic               illegal;
  } dec_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] imm);
    return {{(DATA_W-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction stream, register-file and ALU signals around the
// issue stage. The issue stage connects through master, its environment through slave.
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  // Handshake: INSTR transfers at a rising CLK edge where INSTR_VALID and
  // INSTR_READY are both high and RST is high; VALID may change freely while
  // READY is low, and READY is high only while the stage is idle.
  logic [INSTR_W-1:0] INSTR;
  logic               INSTR_VALID;
  logic               INSTR_READY;
  logic [RADDR_W-1:0] RF_ADDR_R1;
  logic [RADDR_W-1:0] RF_ADDR_R2;
  logic [DATA_W-1:0]  RF_DATA_R1;
  logic [DATA_W-1:0]  RF_DATA_R2;
  logic [RADDR_W-1:0] RF_ADDR_W;
  logic [DATA_W-1:0]  RF_DATA_W;
  logic               RF_WRITE;
  logic [DATA_W-1:0]  ALU_OP1;
  logic [DATA_W-1:0]  ALU_OP2;
  logic [OPRN_W-1:0]  ALU_OPRN;
  logic [DATA_W-1:0]  ALU_OUT;
  logic               ILLEGAL;
  state_t             state_dbg;

  modport master (
    input  INSTR, INSTR_VALID, RF_DATA_R1, RF_DATA_R2, ALU_OUT,
    output INSTR_READY, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W, RF_WRITE,
           ALU_OP1, ALU_OP2, ALU_OPRN, ILLEGAL, state_dbg
  );

  modport slave (
    output INSTR, INSTR_VALID, RF_DATA_R1, RF_DATA_R2, ALU_OUT,
    input  INSTR_READY, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W, RF_WRITE,
           ALU_OP1, ALU_OP2, ALU_OPRN, ILLEGAL, state_dbg
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of one instruction word into ALU opcode, operand
// sources, destination register and an illegal flag.
module alu_issue_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    dec.oprn    = OPRN_NONE;
    dec.op2_sel = OP2_REG;
    dec.op1_sel = OP1_REG;
    dec.dest    = instr[20:16];
    dec.illegal = 1'b0;
    if (opcode == OPC_RTYPE) begin
      dec.dest = instr[15:11];
      case (funct)
        FN_ADD: dec.oprn = OPRN_ADD;
        FN_SUB: dec.oprn = OPRN_SUB;
        FN_MUL: dec.oprn = OPRN_MUL;
        FN_SRL: begin dec.oprn = OPRN_SRL; dec.op2_sel = OP2_SHAMT; end
        FN_SLL: begin dec.oprn = OPRN_SLL; dec.op2_sel = OP2_SHAMT; end
        FN_AND: dec.oprn = OPRN_AND;
        FN_OR:  dec.oprn = OPRN_OR;
        FN_NOR: dec.oprn = OPRN_NOR;
        FN_SLT: dec.oprn = OPRN_SLT;
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OPC_ADDI: begin dec.oprn = OPRN_ADD; dec.op2_sel = OP2_SEXT; end
        OPC_MULI: begin dec.oprn = OPRN_MUL; dec.op2_sel = OP2_SEXT; end
        OPC_SLTI: begin dec.oprn = OPRN_SLT; dec.op2_sel = OP2_SEXT; end
        OPC_ANDI: begin dec.oprn = OPRN_AND; dec.op2_sel = OP2_ZEXT; end
        OPC_ORI:  begin dec.oprn = OPRN_OR;  dec.op2_sel = OP2_ZEXT; end
        // lui is issued as imm << 16 on the ALU shifter
        OPC_LUI: begin
          dec.oprn    = OPRN_SLL;
          dec.op1_sel = OP1_IMM;
          dec.op2_sel = OP2_CONST16;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-phase issue stage in front of the ALU: accept, decode/read operands,
// execute, write back. One instruction in flight at a time.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  alu_issue_ctrl_if.master bus
);

  state_t             state;
  state_t             state_nxt;
  logic               ready_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  op1_q;
  logic [DATA_W-1:0]  op2_q;
  logic [OPRN_W-1:0]  oprn_q;
  logic [RADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]  res_q;
  logic [DATA_W-1:0]  op1_d;
  logic [DATA_W-1:0]  op2_d;
  logic               handshake;
  dec_t               dec;

  alu_issue_decode u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

  // ready_q is only ever high in IDLE, so it alone qualifies the handshake
  assign handshake = bus.INSTR_VALID && ready_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (handshake) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = dec.illegal ? ST_IDLE : ST_EXEC;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op1_d = bus.RF_DATA_R1;
    op2_d = bus.RF_DATA_R2;
    if (dec.op1_sel == OP1_IMM) op1_d = zext16(instr_q[15:0]);
    case (dec.op2_sel)
      OP2_SEXT:    op2_d = sext16(instr_q[15:0]);
      OP2_ZEXT:    op2_d = zext16(instr_q[15:0]);
      OP2_SHAMT:   op2_d = {{(DATA_W-5){1'b0}}, instr_q[10:6]};
      OP2_CONST16: op2_d = DATA_W'(16);
      default:     op2_d = bus.RF_DATA_R2;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      oprn_q  <= '0;
      dest_q  <= '0;
      res_q   <= '0;
    end else begin
      if (state == ST_IDLE && handshake) instr_q <= bus.INSTR;
      if (state == ST_DECODE) begin
        op1_q  <= op1_d;
        op2_q  <= op2_d;
        oprn_q <= dec.oprn;
        dest_q <= dec.dest;
      end
      if (state == ST_EXEC) res_q <= bus.ALU_OUT;
    end
  end

  // Read addresses follow instr_q, so they hold the last decoded fields in IDLE
  always_comb begin
    bus.INSTR_READY = ready_q;
    bus.RF_ADDR_R1  = instr_q[25:21];
    bus.RF_ADDR_R2  = instr_q[20:16];
    bus.ILLEGAL     = (state == ST_DECODE) && dec.illegal;
    bus.ALU_OP1     = '0;
    bus.ALU_OP2     = '0;
    bus.ALU_OPRN    = '0;
    bus.RF_WRITE    = 1'b0;
    bus.RF_ADDR_W   = '0;
    bus.RF_DATA_W   = '0;
    bus.state_dbg   = state;
    if (state == ST_EXEC) begin
      bus.ALU_OP1  = op1_q;
      bus.ALU_OP2  = op2_q;
      bus.ALU_OPRN = oprn_q;
    end
    if (state == ST_WB) begin
      bus.RF_WRITE  = (dest_q != '0);
      bus.RF_ADDR_W = dest_q;
      bus.RF_DATA_W = res_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed instructions with literal expectations,
// then randomized traffic and resets against an instruction-level model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic CLK;
  logic RST;
  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
    case (op)
      6'd1: return a + b;
      6'd2: return a - b;
      6'd3: return a * b;
      6'd4: return a >> b;
      6'd5: return a << b;
      6'd6: return a & b;
      6'd7: return a | b;
      6'd8: return ~(a | b);
      6'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.RF_DATA_R1 = rf[bus.RF_ADDR_R1];
  assign bus.RF_DATA_R2 = rf[bus.RF_ADDR_R2];
  assign bus.ALU_OUT    = alu_ref(bus.ALU_OP1, bus.ALU_OP2, bus.ALU_OPRN);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit          legal;
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [4:0]  dest;
  } exp_t;

  // What the ISA says one instruction should put on the ALU and write back
  function automatic exp_t ref_issue(input logic [31:0] w);
    exp_t r;
    logic [31:0] sx, zx;
    sx = {{16{w[15]}}, w[15:0]};
    zx = {16'h0, w[15:0]};
    r.legal = 1'b1;
    r.oprn  = 6'd0;
    r.op1   = rf[w[25:21]];
    r.op2   = 32'd0;
    r.dest  = w[20:16];
    if (w[31:26] == 6'h00) begin
      r.dest = w[15:11];
      r.op2  = rf[w[20:16]];
      case (w[5:0])
        6'h20: r.oprn = 6'd1;
        6'h22: r.oprn = 6'd2;
        6'h2C: r.oprn = 6'd3;
        6'h02: begin r.oprn = 6'd4; r.op2 = {27'h0, w[10:6]}; end
        6'h01: begin r.oprn = 6'd5; r.op2 = {27'h0, w[10:6]}; end
        6'h24: r.oprn = 6'd6;
        6'h25: r.oprn = 6'd7;
        6'h27: r.oprn = 6'd8;
        6'h2A: r.oprn = 6'd9;
        default: r.legal = 1'b0;
      endcase
    end else begin
      case (w[31:26])
        6'h08: begin r.oprn = 6'd1; r.op2 = sx; end
        6'h1D: begin r.oprn = 6'd3; r.op2 = sx; end
        6'h0A: begin r.oprn = 6'd9; r.op2 = sx; end
        6'h0C: begin r.oprn = 6'd6; r.op2 = zx; end
        6'h0D: begin r.oprn = 6'd7; r.op2 = zx; end
        6'h0F: begin r.oprn = 6'd5; r.op1 = zx; r.op2 = 32'd16; end
        default: r.legal = 1'b0;
      endcase
    end
    r.res = alu_ref(r.op1, r.op2, r.oprn);
    return r;
  endfunction

  // m_age: cycles since acceptance (0 = decode cycle), -1 when nothing in flight
  int          m_age = -1;
  bit          m_ready = 1'b0;
  bit          m_started = 1'b0;
  logic [31:0] m_instr = '0;
  exp_t        m_exp = '0;

  always @(posedge CLK) begin
    m_started <= 1'b1;
    if (!RST) begin
      m_age   <= -1;
      m_ready <= 1'b0;
      m_instr <= '0;
    end else if (bus.INSTR_VALID && m_ready) begin
      m_age   <= 0;
      m_ready <= 1'b0;
      m_instr <= bus.INSTR;
      m_exp   <= ref_issue(bus.INSTR);
    end else if (m_age >= 0) begin
      if (m_age + 1 >= (m_exp.legal ? 3 : 1)) begin
        m_age   <= -1;
        m_ready <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      m_ready <= 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    if (m_started) begin
      check("ready", 32'(bus.INSTR_READY), 32'(m_ready));
      check("illegal", 32'(bus.ILLEGAL), 32'(m_age == 0 && !m_exp.legal));
      check("rf_addr_r1", 32'(bus.RF_ADDR_R1), 32'(m_instr[25:21]));
      check("rf_addr_r2", 32'(bus.RF_ADDR_R2), 32'(m_instr[20:16]));
      check("alu_oprn", 32'(bus.ALU_OPRN), (m_age == 1) ? 32'(m_exp.oprn) : 32'd0);
      check("alu_op1", bus.ALU_OP1, (m_age == 1) ? m_exp.op1 : 32'd0);
      check("alu_op2", bus.ALU_OP2, (m_age == 1) ? m_exp.op2 : 32'd0);
      check("rf_write", 32'(bus.RF_WRITE), 32'(m_age == 2 && m_exp.dest != 5'd0));
      check("rf_addr_w", 32'(bus.RF_ADDR_W), (m_age == 2) ? 32'(m_exp.dest) : 32'd0);
      check("rf_data_w", bus.RF_DATA_W, (m_age == 2) ? m_exp.res : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the decode cycle.
  task automatic send(input logic [31:0] ins);
    bit ok;
    ok = 1'b0;
    bus.INSTR       = ins;
    bus.INSTR_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (bus.INSTR_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("hs_wait", 32'(ok), 32'd1);
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [31:0] ins,
                              input logic [5:0] oprn, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [4:0] dest,
                              input logic [31:0] data);
    send(ins);
    check({tag, "_illegal"}, 32'(bus.ILLEGAL), 32'd0);
    @(negedge CLK);
    check({tag, "_oprn"}, 32'(bus.ALU_OPRN), 32'(oprn));
    check({tag, "_op1"}, bus.ALU_OP1, op1);
    check({tag, "_op2"}, bus.ALU_OP2, op2);
    @(negedge CLK);
    check({tag, "_write"}, 32'(bus.RF_WRITE), 32'(dest != 5'd0));
    check({tag, "_addr_w"}, 32'(bus.RF_ADDR_W), 32'(dest));
    check({tag, "_data_w"}, bus.RF_DATA_W, data);
    @(negedge CLK);
    check({tag, "_ready_back"}, 32'(bus.INSTR_READY), 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 17);
    if (k <= 8) begin
      w[31:26] = 6'h00;
      case (k)
        0: w[5:0] = 6'h20;
        1: w[5:0] = 6'h22;
        2: w[5:0] = 6'h2C;
        3: w[5:0] = 6'h02;
        4: w[5:0] = 6'h01;
        5: w[5:0] = 6'h24;
        6: w[5:0] = 6'h25;
        7: w[5:0] = 6'h27;
        default: w[5:0] = 6'h2A;
      endcase
    end else if (k <= 14) begin
      case (k)
        9:  w[31:26] = 6'h08;
        10: w[31:26] = 6'h1D;
        11: w[31:26] = 6'h0A;
        12: w[31:26] = 6'h0C;
        13: w[31:26] = 6'h0D;
        default: w[31:26] = 6'h0F;
      endcase
    end else if (k == 15) begin
      w[31:26] = 6'h00;
    end
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int writes;
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    RST             = 1'b0;
    bus.INSTR       = 32'h0022_1820;
    bus.INSTR_VALID = 1'b1;

    // Reset held with VALID high: nothing accepted, everything quiet
    repeat (3) begin
      @(negedge CLK);
      check("rst_ready", 32'(bus.INSTR_READY), 32'd0);
      check("rst_write", 32'(bus.RF_WRITE), 32'd0);
      check("rst_oprn", 32'(bus.ALU_OPRN), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    end
    RST             = 1'b1;
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    check("rst_release_ready", 32'(bus.INSTR_READY), 32'd1);

    run_directed("add",  32'h0022_1820, 6'd1, 32'd5, 32'd7, 5'd3, 32'd12);
    run_directed("addi", 32'h2024_FFFF, 6'd1, 32'd5, 32'hFFFF_FFFF, 5'd4, 32'd4);
    run_directed("sll",  32'h0020_2901, 6'd5, 32'd5, 32'd4, 5'd5, 32'd80);
    run_directed("lui",  32'h3C06_1234, 6'd5, 32'h1234, 32'd16, 5'd6, 32'h1234_0000);

    send(32'hFC00_0000);
    check("ill_pulse", 32'(bus.ILLEGAL), 32'd1);
    check("ill_no_write", 32'(bus.RF_WRITE), 32'd0);
    @(negedge CLK);
    check("ill_pulse_end", 32'(bus.ILLEGAL), 32'd0);
    check("ill_ready_back", 32'(bus.INSTR_READY), 32'd1);

    send(32'h0022_0020);
    @(negedge CLK);
    @(negedge CLK);
    check("add0_wb_no_write", 32'(bus.RF_WRITE), 32'd0);
    @(negedge CLK);

    // Reset sampled at the EXEC->WB edge must drop the write entirely
    send(32'h0022_1820);
    @(negedge CLK);
    RST = 1'b0;
    writes = 0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (6) begin
      writes += int'(bus.RF_WRITE);
      @(negedge CLK);
    end
    check("rst_exec_no_write", 32'(writes), 32'd0);

    // Randomized traffic, including VALID while busy and sporadic resets
    for (int c = 0; c < 800; c++) begin
      RST             = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.INSTR_VALID = ($urandom_range(0, 99) < 60);
      bus.INSTR       = rand_instr();
      @(negedge CLK);
    end
    RST             = 1'b1;
    bus.INSTR_VALID = 1'b0;
    repeat (6) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
